// File: rtl/jtframe_pll_rstcen.sv
// Lock synchroniser, stretched game reset and fractional cen/cenb generator for the PLL clock domain.
// cen fires at clk*N/M; cenb runs the same accumulator offset by M/2 units.
module jtframe_pll_rstcen #(
    parameter int W          = 10,
    parameter int N          = 1,
    parameter int M          = 8,
    parameter int RST_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    output logic lock_s,
    output logic rst_game,
    output logic cen,
    output logic cenb,
    output logic lock_lost
);
    localparam int CW = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);
    localparam logic [W:0]    STEP     = (W + 1)'(N);
    localparam logic [W:0]    MODULUS  = (W + 1)'(M);
    localparam logic [W:0]    HALF     = (W + 1)'(M / 2);

    logic          lock_p0;
    logic [CW-1:0] cnt;
    logic [W:0]    acc, acc_b;
    logic [W:0]    sum_a, sum_b;
    logic          wrap_a, wrap_b;

    always_comb begin
        sum_a  = acc + STEP;
        sum_b  = acc_b + STEP;
        wrap_a = sum_a >= MODULUS;
        wrap_b = sum_b >= MODULUS;
    end

    // Two-flop synchroniser: lock_p0 is the only flop that sees pll_locked
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p0 <= pll_locked;
            lock_s  <= lock_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rst_game  <= 1'b1;
            lock_lost <= 1'b0;
        end else begin
            if (!lock_s) begin
                cnt      <= '0;
                rst_game <= 1'b1;
            end else if (rst_game) begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_LAST) rst_game <= 1'b0;
            end
            if (!lock_s && !rst_game) lock_lost <= 1'b1;
        end
    end

    // Accumulators restart from their phase offsets every time the game is held in reset
    always_ff @(posedge clk) begin
        if (rst || rst_game) begin
            acc   <= '0;
            acc_b <= HALF;
            cen   <= 1'b0;
            cenb  <= 1'b0;
        end else begin
            acc   <= wrap_a ? sum_a - MODULUS : sum_a;
            acc_b <= wrap_b ? sum_b - MODULUS : sum_b;
            cen   <= wrap_a;
            cenb  <= wrap_b;
        end
    end
endmodule
